// File: rtl/core_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding, ID width,
// default vector placement and the fixed-priority helper.
package core_pkg;

    localparam int IRQ_ID_W = 3;
    localparam int MAX_IRQ  = 1 << IRQ_ID_W;

    localparam logic [15:0] DEFAULT_VEC_BASE   = 16'h0008;
    localparam int          DEFAULT_VEC_STRIDE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } irq_state_e;

    // Lowest set index wins; scanning downwards lets the last hit be the lowest.
    function automatic logic [IRQ_ID_W-1:0] lowest_set(input logic [MAX_IRQ-1:0] bits);
        logic [IRQ_ID_W-1:0] idx;
        idx = '0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (bits[i]) idx = IRQ_ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-bit synchroniser for the external request lines. With IRQ_EDGE_EN defined, req is a
// one-cycle pulse on each rising edge of the synchronised line; otherwise it is the level itself.
module irq_sync
    import core_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] req
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // NOTE: the whole flop chain is reset; a stale 1 left in any stage would otherwise
    // surface after reset as a request (or a fake rising edge) nobody raised.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take its neighbour's old value,
            // so the chain shifts by exactly one flop per clock regardless of statement order.
            stage_q[0] <= async_in;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

`ifdef IRQ_EDGE_EN
    logic [WIDTH-1:0] last_q;

    always_ff @(posedge clk) begin
        if (reset) last_q <= '0;
        else       last_q <= stage_q[STAGES-1];
    end

    assign req = stage_q[STAGES-1] & ~last_q;
`else
    assign req = stage_q[STAGES-1];
`endif

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises, latches, masks and prioritises request lines and runs the
// request/ack/rti handshake towards the sequencer. Optional macro IRQ_EDGE_EN selects edge mode.
module irq_ctrl
    import core_pkg::*;
#(
    parameter int                  NUM_IRQ     = 4,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  PMA_SIZE    = 16,
    parameter logic [PMA_SIZE-1:0] VEC_BASE    = PMA_SIZE'(DEFAULT_VEC_BASE),
    parameter int                  VEC_STRIDE  = DEFAULT_VEC_STRIDE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                ps_irq_gie,
    input  logic                ps_imask_wen,
    input  logic [NUM_IRQ-1:0]  ps_imask_wdt,
    input  logic                ps_irq_ack,
    input  logic                ps_irq_rti,
    output logic                interrupt,
    output logic [PMA_SIZE-1:0] irq_vec,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [NUM_IRQ-1:0]  irq_pend,
    output logic [NUM_IRQ-1:0]  irq_imask,
    output logic                irq_busy
);

    irq_state_e          state_q;
    logic                interrupt_q;
    logic                busy_q;
    logic [IRQ_ID_W-1:0] id_q;
    logic [PMA_SIZE-1:0] vec_q;
    logic [NUM_IRQ-1:0]  imask_q;
    logic [NUM_IRQ-1:0]  req_evt;
    logic [NUM_IRQ-1:0]  pend;
    logic [NUM_IRQ-1:0]  eligible;
    logic [IRQ_ID_W-1:0] winner;
    logic [PMA_SIZE-1:0] winner_vec;

    irq_sync #(
        .WIDTH  (NUM_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (irq_in),
        .req      (req_evt)
    );

`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] ack_clr;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        ack_clr = '0;
        if (state_q == REQ && ps_irq_ack) ack_clr = NUM_IRQ'(1'b1) << id_q;
    end

    // A new edge arriving in the ack cycle survives: the set term is applied after the clear.
    always_ff @(posedge clk) begin
        if (reset) pend_q <= '0;
        else       pend_q <= (pend_q & ~ack_clr) | req_evt;
    end

    assign pend = pend_q;
`else
    assign pend = req_evt;
`endif

    always_ff @(posedge clk) begin
        if (reset)             imask_q <= '0;
        else if (ps_imask_wen) imask_q <= ps_imask_wdt;
    end

    // Uses the registered mask, so a write in this cycle only affects the next evaluation.
    assign eligible   = ps_irq_gie ? (pend & imask_q) : '0;
    assign winner     = lowest_set(MAX_IRQ'(eligible));
    assign winner_vec = VEC_BASE + PMA_SIZE'(winner) * PMA_SIZE'(VEC_STRIDE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            interrupt_q <= 1'b0;
            busy_q      <= 1'b0;
            id_q        <= '0;
            vec_q       <= VEC_BASE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|eligible) begin
                        id_q        <= winner;
                        vec_q       <= winner_vec;
                        interrupt_q <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                // Committed: id/vec are frozen until the sequencer takes the vector.
                REQ: begin
                    if (ps_irq_ack) begin
                        interrupt_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SVC;
                    end
                end
                SVC: begin
                    if (ps_irq_rti) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    interrupt_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign interrupt = interrupt_q;
    assign irq_vec   = vec_q;
    assign irq_id    = id_q;
    assign irq_pend  = pend;
    assign irq_imask = imask_q;
    assign irq_busy  = busy_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: priority/vector table, handshake corner cases and random traffic,
// every cycle compared against a behavioural model of the controller.
module tb_irq_ctrl;

    localparam int          N   = 4;
    localparam int          S   = 2;
    localparam int          PMA = 16;
    localparam logic [15:0] VB  = 16'h0008;
    localparam int          VS  = 4;
`ifdef IRQ_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    localparam int LAT = EDGE ? S + 2 : S + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   irq_in = '0;
    logic           ps_irq_gie = 1'b0;
    logic           ps_imask_wen = 1'b0;
    logic [N-1:0]   ps_imask_wdt = '0;
    logic           ps_irq_ack = 1'b0;
    logic           ps_irq_rti = 1'b0;
    logic           interrupt;
    logic [PMA-1:0] irq_vec;
    logic [2:0]     irq_id;
    logic [N-1:0]   irq_pend;
    logic [N-1:0]   irq_imask;
    logic           irq_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .NUM_IRQ     (N),
        .SYNC_STAGES (S),
        .PMA_SIZE    (PMA),
        .VEC_BASE    (VB),
        .VEC_STRIDE  (VS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq_in),
        .ps_irq_gie   (ps_irq_gie),
        .ps_imask_wen (ps_imask_wen),
        .ps_imask_wdt (ps_imask_wdt),
        .ps_irq_ack   (ps_irq_ack),
        .ps_irq_rti   (ps_irq_rti),
        .interrupt    (interrupt),
        .irq_vec      (irq_vec),
        .irq_id       (irq_id),
        .irq_pend     (irq_pend),
        .irq_imask    (irq_imask),
        .irq_busy     (irq_busy)
    );

    // Behavioural model: input history for the synchroniser delay, plus raised/busy flags.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_pend;
    logic [N-1:0] m_imask;
    bit           m_int;
    bit           m_busy;
    int           m_id;
    logic [15:0]  m_vec;

    // Synchronised value of the lines 'back' clocks ago: the input sampled S+back edges earlier.
    function automatic logic [N-1:0] m_sync(input int back);
        int k;
        k = hist.size() - S - back;
        return (k >= 0) ? hist[k] : '0;
    endfunction

    task automatic model_update();
        logic [N-1:0] pend_v, elig, rise, clr;
        if (reset) begin
            hist.delete();
            m_pend  = '0;
            m_imask = '0;
            m_int   = 1'b0;
            m_busy  = 1'b0;
            m_id    = 0;
            m_vec   = VB;
        end else begin
            pend_v = EDGE ? m_pend : m_sync(0);
            elig   = ps_irq_gie ? (pend_v & m_imask) : '0;
            rise   = m_sync(0) & ~m_sync(1);
            clr    = '0;
            if (!m_int && !m_busy) begin
                if (elig != '0) begin
                    for (int i = 0; i < N; i++) begin
                        if (elig[i]) begin
                            m_id = i;
                            break;
                        end
                    end
                    m_vec = 16'(VB + m_id * VS);
                    m_int = 1'b1;
                end
            end else if (m_int) begin
                if (ps_irq_ack) begin
                    m_int      = 1'b0;
                    m_busy     = 1'b1;
                    clr[m_id]  = 1'b1;
                end
            end else if (ps_irq_rti) begin
                m_busy = 1'b0;
            end
            m_pend = (m_pend & ~clr) | rise;
            if (ps_imask_wen) m_imask = ps_imask_wdt;
            hist.push_back(irq_in);
            if (hist.size() > S + 1) void'(hist.pop_front());
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("model_interrupt", 32'(interrupt), 32'(m_int));
        check("model_busy", 32'(irq_busy), 32'(m_busy));
        check("model_id", 32'(irq_id), 32'(m_id));
        check("model_vec", 32'(irq_vec), 32'(m_vec));
        check("model_imask", 32'(irq_imask), 32'(m_imask));
        check("model_pend", 32'(irq_pend), 32'(EDGE ? m_pend : m_sync(0)));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic pulse_ack();
        ps_irq_ack = 1'b1;
        step();
        ps_irq_ack = 1'b0;
    endtask

    task automatic pulse_rti();
        ps_irq_rti = 1'b1;
        step();
        ps_irq_rti = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        irq_in       = '0;
        ps_irq_gie   = 1'b0;
        ps_imask_wen = 1'b0;
        ps_imask_wdt = '0;
        ps_irq_ack   = 1'b0;
        ps_irq_rti   = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic setup(input logic [N-1:0] mask);
        ps_imask_wen = 1'b1;
        ps_imask_wdt = mask;
        ps_irq_gie   = 1'b1;
        step();
        ps_imask_wen = 1'b0;
    endtask

    task automatic wait_int(input int max, output int cycles);
        cycles = 0;
        while (!interrupt && cycles < max) begin
            step();
            cycles++;
        end
        check("wait_int_reached", 32'(interrupt), 32'd1);
    endtask

    typedef struct {
        logic [N-1:0] pattern;
        int           exp_id;
        logic [15:0]  exp_vec;
    } row_t;

    row_t rows[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int extra;

        rows[0] = '{4'b0001, 0, 16'h0008};
        rows[1] = '{4'b0010, 1, 16'h000C};
        rows[2] = '{4'b0100, 2, 16'h0010};
        rows[3] = '{4'b1000, 3, 16'h0014};
        rows[4] = '{4'b1010, 1, 16'h000C};
        rows[5] = '{4'b1100, 2, 16'h0010};
        rows[6] = '{4'b1111, 0, 16'h0008};
        rows[7] = '{4'b1001, 0, 16'h0008};

        // Reset values
        do_reset();
        check("reset_interrupt", 32'(interrupt), 32'd0);
        check("reset_vec", 32'(irq_vec), 32'(VB));
        check("reset_id", 32'(irq_id), 32'd0);
        check("reset_pend", 32'(irq_pend), 32'd0);
        check("reset_imask", 32'(irq_imask), 32'd0);
        check("reset_busy", 32'(irq_busy), 32'd0);

        // Priority / vector table with latency
        for (int r = 0; r < 8; r++) begin
            do_reset();
            setup(4'hF);
            irq_in = rows[r].pattern;
            wait_int(20, lat);
            check("row_latency", 32'(lat), 32'(LAT));
            check("row_id", 32'(irq_id), 32'(rows[r].exp_id));
            check("row_vec", 32'(irq_vec), 32'(rows[r].exp_vec));
            irq_in = '0;
            pulse_ack();
            check("row_int_after_ack", 32'(interrupt), 32'd0);
            check("row_busy_after_ack", 32'(irq_busy), 32'd1);
            pulse_rti();
            check("row_busy_after_rti", 32'(irq_busy), 32'd0);
        end

        // Basic: 3-cycle pulse on line 2
        do_reset();
        setup(4'hF);
        irq_in = 4'b0100;
        step(); step(); step();
        irq_in = '0;
        wait_int(10, extra);
        check("basic_latency", 32'(3 + extra), 32'(LAT));
        check("basic_id", 32'(irq_id), 32'd2);
        check("basic_vec", 32'(irq_vec), 32'h0010);
        step(); step();
        check("basic_hold", 32'(interrupt), 32'd1);
        pulse_ack();
        check("basic_ack_int", 32'(interrupt), 32'd0);
        check("basic_ack_busy", 32'(irq_busy), 32'd1);
        check("basic_ack_pend2", 32'(irq_pend[2]), 32'd0);
        pulse_rti();
        check("basic_rti_busy", 32'(irq_busy), 32'd0);

        // Priority: lines 3 and 1 together, 3 follows one cycle after returning to IDLE
        do_reset();
        setup(4'hF);
        irq_in = 4'b1010;
        wait_int(20, lat);
        check("prio_first_id", 32'(irq_id), 32'd1);
        check("prio_first_vec", 32'(irq_vec), 32'h000C);
        irq_in = 4'b1000;
        step(); step(); step();
        pulse_ack();
        pulse_rti();
        check("prio_idle_int", 32'(interrupt), 32'd0);
        step();
        check("prio_second_int", 32'(interrupt), 32'd1);
        check("prio_second_id", 32'(irq_id), 32'd3);
        check("prio_second_vec", 32'(irq_vec), 32'h0014);
        irq_in = '0;
        repeat (S + 1) step();
        pulse_ack();
        pulse_rti();
        step();

        // Masking: pending while masked, raised two cycles after the mask write strobe
        do_reset();
        ps_irq_gie = 1'b1;
        irq_in = 4'b0001;
        repeat (LAT + 2) step();
        check("mask_pend0", 32'(irq_pend[0]), 32'd1);
        check("mask_int_low", 32'(interrupt), 32'd0);
        ps_imask_wen = 1'b1;
        ps_imask_wdt = 4'b0001;
        step();
        ps_imask_wen = 1'b0;
        check("mask_int_after_strobe", 32'(interrupt), 32'd0);
        step();
        check("mask_int_raised", 32'(interrupt), 32'd1);
        check("mask_id", 32'(irq_id), 32'd0);
        irq_in = '0;
        repeat (S + 1) step();
        pulse_ack();
        pulse_rti();
        step();

        // Committed request survives gie drop, mask clear and a higher-priority arrival
        do_reset();
        setup(4'hF);
        irq_in = 4'b0100;
        wait_int(20, lat);
        check("commit_id", 32'(irq_id), 32'd2);
        ps_irq_gie   = 1'b0;
        ps_imask_wen = 1'b1;
        ps_imask_wdt = '0;
        irq_in       = 4'b0101;
        step();
        ps_imask_wen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("commit_int", 32'(interrupt), 32'd1);
            check("commit_id_hold", 32'(irq_id), 32'd2);
        end
        irq_in = '0;
        pulse_ack();
        pulse_rti();
        check("commit_imask", 32'(irq_imask), 32'd0);
        step();

        // Set wins: a new edge on line 1 lands in the ack cycle
        do_reset();
        setup(4'hF);
        irq_in = 4'b0010;
        wait_int(20, lat);
        check("setwin_id", 32'(irq_id), 32'd1);
        irq_in = '0;
        repeat (S + 1) step();
        irq_in = 4'b0010;
        repeat (S) step();
        pulse_ack();
        check("setwin_pend1", 32'(irq_pend[1]), 32'd1);
        check("setwin_busy", 32'(irq_busy), 32'd1);
        check("setwin_int", 32'(interrupt), 32'd0);
        pulse_rti();
        check("setwin_rti_int", 32'(interrupt), 32'd0);
        wait_int(10, lat);
        check("setwin_refire_lat", 32'(lat), 32'd1);
        check("setwin_refire_id", 32'(irq_id), 32'd1);
        irq_in = '0;
        repeat (S + 1) step();
        pulse_ack();
        pulse_rti();
        step();

        // Reset in service with lines 0 and 2 pending
        do_reset();
        setup(4'hF);
        irq_in = 4'b0101;
        wait_int(20, lat);
        check("rst_first_id", 32'(irq_id), 32'd0);
        pulse_ack();
        irq_in = 4'b0100;
        repeat (S + 1) step();
        irq_in = 4'b0101;
        repeat (S + 2) step();
        check("rst_pre_pend", 32'(irq_pend), 32'b0101);
        check("rst_pre_busy", 32'(irq_busy), 32'd1);
        reset  = 1'b1;
        irq_in = '0;
        step();
        reset = 1'b0;
        check("rst_interrupt", 32'(interrupt), 32'd0);
        check("rst_vec", 32'(irq_vec), 32'(VB));
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_pend", 32'(irq_pend), 32'd0);
        check("rst_imask", 32'(irq_imask), 32'd0);
        check("rst_busy", 32'(irq_busy), 32'd0);
        setup(4'hF);
        for (int i = 0; i < 10; i++) begin
            step();
            check("rst_quiet", 32'(interrupt), 32'd0);
        end

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int b;
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) begin
                b = $urandom_range(0, N - 1);
                irq_in[b] = ~irq_in[b];
            end
            ps_irq_gie   = ($urandom_range(0, 9) != 0);
            ps_imask_wen = ($urandom_range(0, 15) == 0);
            ps_imask_wdt = N'($urandom);
            ps_irq_ack   = ($urandom_range(0, 3) == 0);
            ps_irq_rti   = ($urandom_range(0, 3) == 0);
            step();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller sitting directly upstream of the core's single `interrupt` input.
- Synchronises NUM_IRQ external request lines, latches them as pending and applies a mask and a global enable. Resolves fixed priority, lowest index highest.
- Drives one request to the program sequencer, together with the winning vector address and ID.
- Runs a request/acknowledge/return-from-interrupt handshake so only one interrupt is in service at a time.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..8).
- SYNC_STAGES, 2, synchroniser flop depth per line (>=2).
- PMA_SIZE, 16, program-memory address width of the vector output.
- VEC_BASE, 16'h0008, PM address of the vector for IRQ 0.
- VEC_STRIDE, 4, PM words between consecutive vectors.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  NUM_IRQ  asynchronous external request lines.
- ps_irq_gie  in  1  global interrupt enable from PS.
- ps_imask_wen  in  1  mask register write strobe.
- ps_imask_wdt  in  NUM_IRQ  mask write data; 1 = line enabled.
- ps_irq_ack  in  1  PS has taken the vector (1-cycle pulse).
- ps_irq_rti  in  1  PS executed return-from-interrupt (1-cycle pulse).
- interrupt  out  1  request to PS.
- irq_vec  out  PMA_SIZE  vector address of the request being raised or serviced.
- irq_id  out  3  index of the active interrupt.
- irq_pend  out  NUM_IRQ  pending register, for readback.
- irq_imask  out  NUM_IRQ  current mask register.
- irq_busy  out  1  an interrupt is in service.

Behaviour:
- Reset values: interrupt=0, irq_vec=VEC_BASE, irq_id=0, irq_pend=0, irq_imask=0 (all masked), irq_busy=0, synchronisers cleared, FSM=IDLE.
- Reset asserted mid-handshake aborts the handshake and discards all pending bits.
- Synchroniser: SYNC_STAGES flops per line; sync[i] is the last stage.
- Pending, IRQ_EDGE_EN defined: a rising edge of sync[i] sets pend[i] the next cycle.
- Pending, IRQ_EDGE_EN undefined: see Optional Feature.
- Mask: written on ps_imask_wen and takes effect the next cycle. Masking does not clear pend.
- eligible = pend & imask, gated by ps_irq_gie. winner = lowest set index of eligible.
- FSM IDLE:
  - if eligible != 0: latch irq_id=winner, irq_vec=VEC_BASE+winner*VEC_STRIDE (modulo 2^PMA_SIZE), interrupt=1 the next cycle, go REQ.
  - ack and rti are ignored in IDLE.
- FSM REQ:
  - interrupt held high and irq_id/irq_vec stable until ps_irq_ack.
  - The request is committed: a later mask, gie drop or higher-priority arrival does not withdraw or re-prioritise it.
  - On ack: interrupt=0 and irq_busy=1 the next cycle, pend[irq_id] cleared (edge mode), go SVC.
  - rti is ignored in REQ.
- FSM SVC:
  - No new request is raised; nesting is not supported.
  - On ps_irq_rti: irq_busy=0, go IDLE.
  - The next eligible interrupt can raise interrupt at the earliest 1 cycle after returning to IDLE.
  - ack is ignored in SVC.
- Simultaneous set and clear on the same pend bit (new edge in the ack cycle): set wins, bit stays pending.
- Simultaneous ps_imask_wen and FSM evaluation: the evaluation uses the old mask.
- Latency, edge mode: irq_in rising edge to interrupt=1 is SYNC_STAGES+2 cycles when IDLE, unmasked and gie=1.

Optional Feature:
- Macro IRQ_EDGE_EN.
- Defined: edge-triggered pending latch as described; ack clears the serviced bit; irq_pend reflects latched edges.
- Undefined: level mode.
  - pend = sync directly; no latch.
  - Ack does not clear pend; the source must deassert before rti or it re-fires.
  - Latency becomes SYNC_STAGES+1 cycles.

Decomposition:
- Shared package (core_pkg): FSM state encoding (IDLE=2'd0, REQ=2'd1, SVC=2'd2), IRQ_ID_W=3, default VEC_BASE/VEC_STRIDE constants.
- One sub-module, irq_sync: a parameterised multi-bit synchroniser, plus an edge detector under IRQ_EDGE_EN.
- Priority encoder and FSM stay in irq_ctrl.

Test Plan:
- Basic: imask=4'b1111, gie=1, pulse irq_in[2] for 3 cycles. interrupt rises SYNC_STAGES+2 cycles later with irq_id=2, irq_vec=16'h0010. Ack gives interrupt=0, irq_busy=1, pend[2]=0. rti gives irq_busy=0.
- Priority: assert irq_in[3] and irq_in[1] in the same cycle. First request is id 1 (vec 16'h000C). After ack+rti, id 3 (vec 16'h0014) is raised 1 cycle after returning to IDLE.
- Masking: imask=4'b0000, pulse irq_in[0]. pend[0]=1, interrupt stays 0. Write imask=4'b0001; interrupt rises 2 cycles after the write strobe.
- Committed request: in REQ with id 2, clear gie and set imask=0. interrupt stays 1 with irq_id=2 until ack.
- Set-wins: new rising edge on the same line whose pend-set cycle coincides with the ack cycle. pend stays 1, and the interrupt re-fires after rti.
- Reset mid-SVC: assert reset while irq_busy=1 with pend=4'b0101. Next cycle all outputs are at reset values and no interrupt is raised afterwards without new edges.
